pipeline_wb: RTL and testbench
==============================

Name: pipeline_wb

Overview:
MEM/WB pipeline register and write-back stage of the pipelined MIPS core. It sits directly downstream of the memory stage and captures that stage's address/ALU result and read data. It performs sub-word load extraction and selects the write-back source, then drives the register-file write port. It also generates the store-data forwarding select (Forwardsw) and the WB-stage data (WB_dataB) that the memory stage consumes. A retired-instruction counter is included for debug and performance.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hold all WB registers this cycle
flush  in  1  load a bubble this cycle; overrides stall
Mem_Valid  in  1  MEM stage holds a real instruction
Mem_RegWr  in  1  instruction writes register file
Mem_MemWr  in  1  instruction in MEM is a store
Mem_MemToReg  in  2  write-back source: 00 ALU, 01 memory, 10 PC+4, 11 treated as 00
Mem_LoadType  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others = lw
Mem_WriteAddr  in  5  destination register
Mem_Rt  in  5  rt of instruction in MEM (store data source)
Mem_outA  in  32  ALU result / memory address from MEM stage
Mem_outB  in  32  read data from MEM stage
Mem_PC4  in  32  PC+4 of instruction in MEM
WB_RegWr  out  1  register-file write enable
WB_WriteAddr  out  5  register-file write address
WB_dataB  out  32  register-file write data
WB_Valid  out  1  WB holds a real instruction
Forwardsw  out  1  MEM store data must come from WB_dataB
retired  out  CNT_W  count of instructions captured into WB

Behaviour:
- Reset (reset=0, async): WB_RegWr=0, WB_WriteAddr=0, WB_dataB=0, WB_Valid=0, retired=0. Forwardsw then evaluates to 0.
- Latency: one cycle. MEM inputs at edge N appear on WB_* after edge N.
- Capture (flush=0, stall=0):
  - WB_Valid<=Mem_Valid.
  - WB_RegWr<=Mem_Valid & Mem_RegWr & (Mem_WriteAddr!=0). Writes to $0 are suppressed.
  - WB_WriteAddr<=Mem_WriteAddr.
  - WB_dataB<=selected data.
- Stall (flush=0, stall=1): all registers, including retired, hold.
- Flush (flush=1, regardless of stall): WB_Valid<=0, WB_RegWr<=0, WB_WriteAddr<=0, WB_dataB<=0. retired holds.
- Data select:
  - 00/11: Mem_outA.
  - 10: Mem_PC4.
  - 01: extracted load.
- Load extraction (off = Mem_outA[1:0], little-endian):
  - lb/lbu: byte = Mem_outB[8*off+7 : 8*off], sign- or zero-extended.
  - lh/lhu: half = Mem_outA[1] ? Mem_outB[31:16] : Mem_outB[15:0], sign- or zero-extended. off[0] is ignored (no misalign trap).
  - lw: Mem_outB unchanged; off ignored.
- Forwardsw (combinational from current WB registers and MEM inputs) = Mem_MemWr & WB_RegWr & (WB_WriteAddr==Mem_Rt).
  - Because $0 writes are suppressed, Forwardsw can never assert for Rt=0.
  - Asserting during stall is permitted; WB contents are stable then.
- retired increments by 1 on each capture with Mem_Valid=1. It wraps from all-ones to 0 with no flag.
- Reset asserted mid-stall or mid-flush: all outputs clear immediately. On reset release, the first edge captures normally.

Test Plan:
- Reset, then lb. Mem_outB=32'h80FF7F01, Mem_outA=32'h1000_0003, LoadType=001, MemToReg=01, RegWr=1, WriteAddr=8, Valid=1 -> next cycle WB_dataB=32'hFFFFFF80, WB_RegWr=1, WB_WriteAddr=8, retired=1. Repeat with lbu, off=1 -> 32'h0000007F.
- lh/lhu. Mem_outB=32'h8001_F00F, Mem_outA[1]=1 -> lh gives 32'hFFFF8001, lhu gives 32'h00008001. Mem_outA[1:0]=01 with lh -> 32'hFFFFF00F.
- jal and $0. MemToReg=10, Mem_PC4=32'h0040_0010, WriteAddr=31 -> WB_dataB=32'h0040_0010. ALU write with WriteAddr=0 -> WB_RegWr=0, WB_Valid=1.
- Store forward. WB holds RegWr=1, WriteAddr=9. Mem_MemWr=1, Mem_Rt=9 -> Forwardsw=1. Change Mem_Rt to 10 -> 0. WB_RegWr=0 with WriteAddr=9 -> 0.
- Stall/flush. stall=1 for 3 cycles with changing inputs -> outputs and retired frozen. flush=1 with stall=1 -> bubble: WB_Valid=0, WB_RegWr=0, WB_dataB=0, retired unchanged.
- Counter wrap and async reset. Use CNT_W=4 with 16 valid captures -> retired=0. Pull reset low mid-cycle -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/pipeline_wb.sv
// Purpose : MEM/WB pipeline register and write-back stage. Extracts sub-word loads, selects the
//           write-back source, drives the regfile write port and the store-data forward select.
// Latency : one cycle from MEM inputs to WB outputs; Forwardsw is combinational.
// Backpress: stall holds every WB register including retired; flush loads a bubble and beats stall.
module pipeline_wb #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             Mem_Valid,
   input  logic             Mem_RegWr,
   input  logic             Mem_MemWr,
   input  logic [1:0]       Mem_MemToReg,
   input  logic [2:0]       Mem_LoadType,
   input  logic [4:0]       Mem_WriteAddr,
   input  logic [4:0]       Mem_Rt,
   input  logic [31:0]      Mem_outA,
   input  logic [31:0]      Mem_outB,
   input  logic [31:0]      Mem_PC4,
   output logic             WB_RegWr,
   output logic [4:0]       WB_WriteAddr,
   output logic [31:0]      WB_dataB,
   output logic             WB_Valid,
   output logic             Forwardsw,
   output logic [CNT_W-1:0] retired
);

   // Load-type encodings as seen on Mem_LoadType; anything else behaves as lw.
   localparam logic [2:0] LT_LW  = 3'b000;
   localparam logic [2:0] LT_LB  = 3'b001;
   localparam logic [2:0] LT_LBU = 3'b010;
   localparam logic [2:0] LT_LH  = 3'b011;
   localparam logic [2:0] LT_LHU = 3'b100;

   // Write-back source encodings; 2'b11 falls through to the ALU result.
   localparam logic [1:0] WBS_ALU = 2'b00;
   localparam logic [1:0] WBS_MEM = 2'b01;
   localparam logic [1:0] WBS_PC4 = 2'b10;

   // Pipeline state
   logic             valid_q,  valid_d;
   logic             regwr_q,  regwr_d;
   logic [4:0]       waddr_q,  waddr_d;
   logic [31:0]      data_q,   data_d;
   logic [CNT_W-1:0] ret_q,    ret_d;

   // Datapath intermediates
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_ext;
   logic [31:0] wb_sel_data;
   logic        capture;

   // Pick the addressed byte/half out of the little-endian read word.
   always_comb begin
      load_byte = Mem_outB[7:0];
      case (Mem_outA[1:0])
         2'd0:    load_byte = Mem_outB[7:0];
         2'd1:    load_byte = Mem_outB[15:8];
         2'd2:    load_byte = Mem_outB[23:16];
         default: load_byte = Mem_outB[31:24];
      endcase
      // Halfword alignment only looks at bit 1; a misaligned lh just reads the enclosing half.
      load_half = Mem_outA[1] ? Mem_outB[31:16] : Mem_outB[15:0];
   end

   // Sign/zero extension by load type.
   always_comb begin
      load_ext = Mem_outB;
      case (Mem_LoadType)
         LT_LB:   load_ext = {{24{load_byte[7]}}, load_byte};
         LT_LBU:  load_ext = {24'h000000, load_byte};
         LT_LH:   load_ext = {{16{load_half[15]}}, load_half};
         LT_LHU:  load_ext = {16'h0000, load_half};
         LT_LW:   load_ext = Mem_outB;
         default: load_ext = Mem_outB;
      endcase
   end

   // Write-back source mux.
   always_comb begin
      wb_sel_data = Mem_outA;
      case (Mem_MemToReg)
         WBS_MEM: wb_sel_data = load_ext;
         WBS_PC4: wb_sel_data = Mem_PC4;
         WBS_ALU: wb_sel_data = Mem_outA;
         default: wb_sel_data = Mem_outA;
      endcase
   end

   assign capture = !flush && !stall;

   // Next-state: flush bubble wins over stall; stall holds; otherwise capture MEM.
   always_comb begin
      valid_d = valid_q;
      regwr_d = regwr_q;
      waddr_d = waddr_q;
      data_d  = data_q;
      ret_d   = ret_q;
      if (flush) begin
         valid_d = 1'b0;
         regwr_d = 1'b0;
         waddr_d = 5'd0;
         data_d  = 32'h0000_0000;
      end else if (!stall) begin
         valid_d = Mem_Valid;
         // $0 is hard-wired zero, so never raise a write for it.
         regwr_d = Mem_Valid && Mem_RegWr && (Mem_WriteAddr != 5'd0);
         waddr_d = Mem_WriteAddr;
         data_d  = wb_sel_data;
      end
      // Counter wraps silently at all-ones.
      if (capture && Mem_Valid) begin
         ret_d = ret_q + CNT_W'(1);
      end
   end

   // WB register bank, asynchronously cleared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         regwr_q <= 1'b0;
         waddr_q <= 5'd0;
         data_q  <= 32'h0000_0000;
         ret_q   <= '0;
      end else begin
         valid_q <= valid_d;
         regwr_q <= regwr_d;
         waddr_q <= waddr_d;
         data_q  <= data_d;
         ret_q   <= ret_d;
      end
   end

   // A store in MEM whose rt is being written by WB must take its data from WB_dataB.
   assign Forwardsw = Mem_MemWr && regwr_q && (waddr_q == Mem_Rt);

   assign WB_Valid     = valid_q;
   assign WB_RegWr     = regwr_q;
   assign WB_WriteAddr = waddr_q;
   assign WB_dataB     = data_q;
   assign retired      = ret_q;

endmodule

// File: tb/tb_pipeline_wb.sv
// Purpose : randomized + directed bench for pipeline_wb against a behavioural WB model.
// Latency : checks WB outputs #1 after each rising edge; Forwardsw before the edge.
// Backpress: exercises stall, flush, flush-over-stall and async reset mid-cycle.
module tb_pipeline_wb;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, stall, flush;
   logic             Mem_Valid, Mem_RegWr, Mem_MemWr;
   logic [1:0]       Mem_MemToReg;
   logic [2:0]       Mem_LoadType;
   logic [4:0]       Mem_WriteAddr, Mem_Rt;
   logic [31:0]      Mem_outA, Mem_outB, Mem_PC4;
   logic             WB_RegWr, WB_Valid, Forwardsw;
   logic [4:0]       WB_WriteAddr;
   logic [31:0]      WB_dataB;
   logic [CNT_W-1:0] retired;

   pipeline_wb #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .Mem_Valid(Mem_Valid), .Mem_RegWr(Mem_RegWr), .Mem_MemWr(Mem_MemWr),
      .Mem_MemToReg(Mem_MemToReg), .Mem_LoadType(Mem_LoadType),
      .Mem_WriteAddr(Mem_WriteAddr), .Mem_Rt(Mem_Rt),
      .Mem_outA(Mem_outA), .Mem_outB(Mem_outB), .Mem_PC4(Mem_PC4),
      .WB_RegWr(WB_RegWr), .WB_WriteAddr(WB_WriteAddr), .WB_dataB(WB_dataB),
      .WB_Valid(WB_Valid), .Forwardsw(Forwardsw), .retired(retired)
   );

   int n_chk = 0;
   int n_bad = 0;

   // Reference model of WB contents
   bit          m_valid, m_regwr;
   int unsigned m_addr;
   logic [31:0] m_data;
   int unsigned m_ret;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Write-back value computed straight from the load/select rules with plain arithmetic.
   function automatic logic [31:0] ref_data(input int unsigned mtr, input int unsigned lt,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] pc4);
      int unsigned off, byte_v, half_v;
      off    = a % 4;
      byte_v = (b >> (8 * off)) % 256;
      half_v = ((a / 2) % 2 == 1) ? (b >> 16) : (b % 65536);
      if (mtr == 2) return pc4;
      if (mtr != 1) return a;
      case (lt)
         1:       return (byte_v >= 128) ? (32'hFFFF_FF00 | byte_v) : byte_v;
         2:       return byte_v;
         3:       return (half_v >= 32768) ? (32'hFFFF_0000 | half_v) : half_v;
         4:       return half_v;
         default: return b;
      endcase
   endfunction

   task automatic set_in(input bit v, input bit rw, input bit mw, input int unsigned mtr,
                         input int unsigned lt, input int unsigned wa, input int unsigned rt,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc4);
      Mem_Valid = v; Mem_RegWr = rw; Mem_MemWr = mw;
      Mem_MemToReg = mtr[1:0]; Mem_LoadType = lt[2:0];
      Mem_WriteAddr = wa[4:0]; Mem_Rt = rt[4:0];
      Mem_outA = a; Mem_outB = b; Mem_PC4 = pc4;
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, ".valid"}, WB_Valid, m_valid);
      chk({tag, ".regwr"}, WB_RegWr, m_regwr);
      chk({tag, ".addr"},  WB_WriteAddr, m_addr);
      chk({tag, ".data"},  WB_dataB, m_data);
      chk({tag, ".ret"},   retired, m_ret);
   endtask

   task automatic model_reset();
      m_valid = 0; m_regwr = 0; m_addr = 0; m_data = 0; m_ret = 0;
   endtask

   // One clock: check forward select on current state, advance the model, check WB outputs.
   task automatic cycle(input string tag);
      bit          nv, nrw;
      int unsigned na, nr;
      logic [31:0] nd;
      #1;
      chk({tag, ".fwd"}, Forwardsw,
          (Mem_MemWr && m_regwr && m_addr == Mem_Rt) ? 32'd1 : 32'd0);
      nv = m_valid; nrw = m_regwr; na = m_addr; nd = m_data; nr = m_ret;
      if (flush) begin
         nv = 0; nrw = 0; na = 0; nd = 0;
      end else if (!stall) begin
         nv  = Mem_Valid;
         nrw = Mem_Valid && Mem_RegWr && Mem_WriteAddr != 0;
         na  = Mem_WriteAddr;
         nd  = ref_data(Mem_MemToReg, Mem_LoadType, Mem_outA, Mem_outB, Mem_PC4);
         if (Mem_Valid) nr = (m_ret + 1) % (1 << CNT_W);
      end
      @(posedge clk);
      #1;
      m_valid = nv; m_regwr = nrw; m_addr = na; m_data = nd; m_ret = nr;
      chk_outs(tag);
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #12;
      chk_outs("reset");
      chk("reset.fwd", Forwardsw, 0);
      @(negedge clk);
      reset = 1'b1;

      // Sub-word loads
      set_in(1, 1, 0, 1, 1, 8, 0, 32'h1000_0003, 32'h80FF_7F01, 0);
      cycle("lb");
      chk("lb.exact", WB_dataB, 32'hFFFF_FF80);
      chk("lb.ret1", retired, 1);
      set_in(1, 1, 0, 1, 2, 8, 0, 32'h1000_0001, 32'h80FF_7F01, 0);
      cycle("lbu");
      chk("lbu.exact", WB_dataB, 32'h0000_007F);
      set_in(1, 1, 0, 1, 3, 5, 0, 32'h1000_0002, 32'h8001_F00F, 0);
      cycle("lh");
      chk("lh.exact", WB_dataB, 32'hFFFF_8001);
      set_in(1, 1, 0, 1, 4, 5, 0, 32'h1000_0002, 32'h8001_F00F, 0);
      cycle("lhu");
      chk("lhu.exact", WB_dataB, 32'h0000_8001);
      set_in(1, 1, 0, 1, 3, 5, 0, 32'h1000_0001, 32'h8001_F00F, 0);
      cycle("lh_mis");
      chk("lh_mis.exact", WB_dataB, 32'hFFFF_F00F);

      // jal and $0 write suppression
      set_in(1, 1, 0, 2, 0, 31, 0, 32'h1234_5678, 0, 32'h0040_0010);
      cycle("jal");
      chk("jal.exact", WB_dataB, 32'h0040_0010);
      set_in(1, 1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);
      cycle("r0");
      chk("r0.regwr", WB_RegWr, 0);
      chk("r0.valid", WB_Valid, 1);

      // Store forwarding, then hold WB via stall while Mem_Rt moves
      set_in(1, 1, 0, 0, 0, 9, 0, 32'h0000_0099, 0, 0);
      cycle("wr9");
      stall = 1'b1;
      set_in(1, 0, 1, 0, 0, 3, 9, 0, 0, 0);
      #1 chk("fwd.rt9", Forwardsw, 1);
      cycle("fwd_st1");
      Mem_Rt = 5'd10;
      #1 chk("fwd.rt10", Forwardsw, 0);
      cycle("fwd_st2");
      stall = 1'b0;
      set_in(1, 0, 0, 0, 0, 9, 0, 32'h55, 0, 0);
      cycle("wr9_norw");
      set_in(1, 0, 1, 0, 0, 3, 9, 0, 0, 0);
      #1 chk("fwd.norw", Forwardsw, 0);

      // Stall three cycles with changing inputs, then flush under stall
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_in(1, 1, 0, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(1, 31), 0,
                $urandom, $urandom, $urandom);
         cycle("stall");
      end
      flush = 1'b1;
      cycle("flush");
      chk("flush.data", WB_dataB, 0);
      flush = 1'b0; stall = 1'b0;

      // Counter wrap: 16 valid captures bring a 4-bit counter back to its start
      begin
         int unsigned start;
         start = m_ret;
         for (int i = 0; i < 16; i++) begin
            set_in(1, 1, 0, 0, 0, $urandom_range(0, 31), 0, $urandom, 0, 0);
            cycle("wrap");
         end
         chk("wrap.ret", retired, start);
      end

      // Randomized traffic; small register range makes forwarding hits frequent
      for (int i = 0; i < 600; i++) begin
         stall = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 9) == 0);
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom, $urandom, $urandom);
         cycle("rnd");
      end
      stall = 1'b0; flush = 1'b0;

      // Async reset mid-cycle after a real capture
      set_in(1, 1, 0, 0, 0, 7, 7, 32'hCAFE_0001, 0, 0);
      cycle("pre_rst");
      Mem_MemWr = 1'b1;
      #2 reset = 1'b0;
      #1;
      model_reset();
      chk_outs("arst");
      chk("arst.fwd", Forwardsw, 0);
      @(negedge clk);
      reset = 1'b1;
      set_in(1, 1, 0, 1, 0, 12, 0, 32'h0000_0000, 32'hA5A5_5A5A, 0);
      cycle("post_rst");
      chk("post_rst.ret", retired, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got=running expected=done");
      $fatal(1, "timeout");
   end
endmodule
